trng_key_reader: RTL and testbench
==================================

TRNG_KEY_READER -- requirements
Module: trng_key_reader

Interface
REQ-001 SHALL have parameter N_BITS_KEY, default 512: width of the key captured from the TRNG; a multiple of WORD_W.
REQ-002 SHALL have parameter WORD_W, default 32: width of each output word; N_WORDS = N_BITS_KEY/WORD_W.
REQ-003 SHALL have parameter CNT_W, default 16: width of the served-key counter.
REQ-004 SHALL have port clk_i, input, 1: single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port key_ready_i, input, 1: TRNG key valid.
REQ-007 SHALL have port key_i, input, N_BITS_KEY: TRNG key.
REQ-008 SHALL have port trng_intr_i, input, 1: TRNG total-failure interrupt.
REQ-009 SHALL have port ack_read_o, output, 1: key consumed; returned to the TRNG.
REQ-010 SHALL have port word_valid_o, output, 1: word_data_o valid.
REQ-011 SHALL have port word_ready_i, input, 1: downstream accepts a word.
REQ-012 SHALL have port word_data_o, output, WORD_W: current key word.
REQ-013 SHALL have port word_last_o, output, 1: current word is index N_WORDS-1.
REQ-014 SHALL have port flush_i, input, 1: discard the buffered key.
REQ-015 SHALL have port fail_o, output, 1: sticky TRNG failure flag.
REQ-016 SHALL have port keys_served_o, output, CNT_W: count of fully delivered keys.

Function
REQ-017 SHALL implement FSM states WAIT_KEY, ACK, SERVE and FAIL; all outputs registered or decoded from registered state only.
REQ-018 WAIT_KEY with key_ready_i=1 at an edge SHALL load key_i into the internal buffer, clear the word index to 0 and move to ACK.
REQ-019 In ACK, ack_read_o SHALL be 1 for exactly one cycle, after which the FSM SHALL move to SERVE; ack_read_o SHALL be 0 in all other states.
REQ-020 Latency: key_ready_i sampled at edge t SHALL give ack_read_o=1 in cycle t+1 and word_valid_o=1 in cycle t+2.
REQ-021 In SERVE, word_valid_o SHALL be 1 and word_data_o SHALL equal buffer[idx*WORD_W +: WORD_W]; word 0 is the LSW.
REQ-022 A transfer occurs when word_valid_o=1 and word_ready_i=1 at the same edge; idx SHALL then increment by 1.
REQ-023 With word_ready_i=0, word_data_o and idx SHALL hold stable.
REQ-024 word_last_o SHALL equal (state==SERVE && idx==N_WORDS-1).
REQ-025 A transfer with word_last_o=1 SHALL return the FSM to WAIT_KEY, clear idx, zero the buffer and increment keys_served_o.
REQ-026 keys_served_o SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-027 key_ready_i in any state other than WAIT_KEY SHALL be ignored; no capture and no ack.
REQ-028 flush_i=1 in ACK or SERVE SHALL zero the buffer, clear idx and move to WAIT_KEY at the next edge; no transfer is counted in that cycle, even if word_ready_i=1.
REQ-029 flush_i during an ACK cycle SHALL NOT suppress that cycle's ack_read_o pulse.
REQ-030 flush_i in WAIT_KEY SHALL have no effect; if key_ready_i=1 in the same cycle, the capture SHALL proceed.
REQ-031 trng_intr_i=1 in any state SHALL move the FSM to FAIL at the next edge and zero the buffer; this SHALL take priority over flush_i, transfers and capture.
REQ-032 FAIL SHALL be exited only by rst_i; in FAIL, fail_o=1, word_valid_o=0, ack_read_o=0 and word_data_o=0.
REQ-033 word_data_o SHALL be 0 whenever word_valid_o=0.

Reset
REQ-034 rst_i=1 at an edge SHALL force state=WAIT_KEY, idx=0, buffer=0, ack_read_o=0, word_valid_o=0, word_data_o=0, word_last_o=0, fail_o=0 and keys_served_o=0.
REQ-035 rst_i SHALL override all other inputs, including mid-SERVE and FAIL.

Verification
REQ-036 Nominal key: key_ready_i=1 with key_i={16{words 0x0..0xF}}, word_ready_i=1 -> ack pulse at t+1; words 0x0..0xF on t+2..t+17; word_last_o on 0xF; keys_served_o=1.
REQ-037 Backpressure: word_ready_i toggling 1-0-1 -> no word dropped or duplicated; data held stable while ready=0.
REQ-038 Flush mid-SERVE after 5 transfers -> WAIT_KEY next cycle; word_valid_o=0; keys_served_o unchanged; next key starts at word 0.
REQ-039 trng_intr_i asserted in SERVE with flush_i=1 in the same cycle -> fail_o=1 and word_valid_o=0; later key_ready_i gives no ack; rst_i clears fail_o.
REQ-040 Counter saturation with CNT_W=2, 5 keys served -> keys_served_o stays 3.
REQ-041 Reset mid-SERVE -> all outputs 0 next cycle; a fresh key_ready_i is acked at t+1.

Source files
------------

// File: rtl/trng_key_reader.sv
// Captures a full-width key from the TRNG, acknowledges it, then streams it out
// LSW first as WORD_W words over a valid/ready handshake.
module trng_key_reader #(
  parameter int N_BITS_KEY = 512,
  parameter int WORD_W     = 32,
  parameter int CNT_W      = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  key_ready_i,
  input  logic [N_BITS_KEY-1:0] key_i,
  input  logic                  trng_intr_i,
  output logic                  ack_read_o,
  output logic                  word_valid_o,
  input  logic                  word_ready_i,
  output logic [WORD_W-1:0]     word_data_o,
  output logic                  word_last_o,
  input  logic                  flush_i,
  output logic                  fail_o,
  output logic [CNT_W-1:0]      keys_served_o
);

  localparam int N_WORDS = N_BITS_KEY / WORD_W;
  localparam int IDX_W   = (N_WORDS > 1) ? $clog2(N_WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_WORDS - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    WAIT_KEY = 2'd0,
    ACK      = 2'd1,
    SERVE    = 2'd2,
    FAIL     = 2'd3
  } state_t;

  state_t                  state_reg, state_next;
  logic [N_BITS_KEY-1:0]   buffer_reg, buffer_next;
  logic [IDX_W-1:0]        idx_reg, idx_next;
  logic [CNT_W-1:0]        keys_reg, keys_next;

  logic [WORD_W-1:0]       word_array [N_WORDS];
  logic                    in_serve;
  logic                    at_last;

  // Slice the buffer into words so the output is a plain indexed select.
  for (genvar gi = 0; gi < N_WORDS; gi++) begin : g_words
    assign word_array[gi] = buffer_reg[gi*WORD_W +: WORD_W];
  end

  assign in_serve = (state_reg == SERVE);
  assign at_last  = in_serve && (idx_reg == LAST_IDX);

  always_comb begin
    state_next  = state_reg;
    buffer_next = buffer_reg;
    idx_next    = idx_reg;
    keys_next   = keys_reg;

    // A TRNG failure beats flush, transfer and capture alike.
    if (trng_intr_i) begin
      state_next  = FAIL;
      buffer_next = '0;
      idx_next    = '0;
    end else begin
      case (state_reg)
        WAIT_KEY: begin
          if (key_ready_i) begin
            buffer_next = key_i;
            idx_next    = '0;
            state_next  = ACK;
          end
        end
        ACK: begin
          if (flush_i) begin
            buffer_next = '0;
            idx_next    = '0;
            state_next  = WAIT_KEY;
          end else begin
            state_next  = SERVE;
          end
        end
        SERVE: begin
          if (flush_i) begin
            buffer_next = '0;
            idx_next    = '0;
            state_next  = WAIT_KEY;
          end else if (word_ready_i) begin
            if (at_last) begin
              buffer_next = '0;
              idx_next    = '0;
              state_next  = WAIT_KEY;
              if (keys_reg != CNT_MAX) begin
                keys_next = keys_reg + CNT_W'(1);
              end
            end else begin
              idx_next = idx_reg + IDX_W'(1);
            end
          end
        end
        FAIL: begin
          buffer_next = '0;
          idx_next    = '0;
        end
        default: begin
          state_next  = WAIT_KEY;
          buffer_next = '0;
          idx_next    = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg  <= WAIT_KEY;
      buffer_reg <= '0;
      idx_reg    <= '0;
      keys_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      buffer_reg <= buffer_next;
      idx_reg    <= idx_next;
      keys_reg   <= keys_next;
    end
  end

  // Outputs are decoded purely from registered state, so flush or intr
  // arriving in ACK cannot cut that cycle's ack pulse short.
  assign ack_read_o    = (state_reg == ACK);
  assign word_valid_o  = in_serve;
  assign word_data_o   = in_serve ? word_array[idx_reg] : '0;
  assign word_last_o   = at_last;
  assign fail_o        = (state_reg == FAIL);
  assign keys_served_o = keys_reg;

endmodule

// File: tb/tb_trng_key_reader.sv
// Directed bench for trng_key_reader: nominal stream, backpressure, flush,
// failure, reset and counter saturation (second instance with a 2-bit counter).
module tb_trng_key_reader;

  localparam int NB = 512;
  localparam int WW = 32;
  localparam int NW = NB / WW;

  logic          clk = 1'b0;
  logic          rst, key_ready, trng_intr, word_ready, flush;
  logic [NB-1:0] key;

  logic          ack, valid, last, fail;
  logic [WW-1:0] data;
  logic [15:0]   served;

  logic          sat_ack, sat_valid, sat_last, sat_fail;
  logic [WW-1:0] sat_data;
  logic [1:0]    sat_served;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  trng_key_reader #(.N_BITS_KEY(NB), .WORD_W(WW), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst), .key_ready_i(key_ready), .key_i(key),
    .trng_intr_i(trng_intr), .ack_read_o(ack), .word_valid_o(valid),
    .word_ready_i(word_ready), .word_data_o(data), .word_last_o(last),
    .flush_i(flush), .fail_o(fail), .keys_served_o(served)
  );

  trng_key_reader #(.N_BITS_KEY(NB), .WORD_W(WW), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_i(rst), .key_ready_i(key_ready), .key_i(key),
    .trng_intr_i(trng_intr), .ack_read_o(sat_ack), .word_valid_o(sat_valid),
    .word_ready_i(word_ready), .word_data_o(sat_data), .word_last_o(sat_last),
    .flush_i(flush), .fail_o(sat_fail), .keys_served_o(sat_served)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Key k: word i = (k << 16) | i, so key 0 carries words 0x0..0xF.
  function automatic logic [NB-1:0] make_key(input int k);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NW; i++) r[i*WW +: WW] = (32'(k) << 16) | 32'(i);
    return r;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_ack"},   64'(ack),    64'd0);
    check({tag, "_valid"}, 64'(valid),  64'd0);
    check({tag, "_data"},  64'(data),   64'd0);
    check({tag, "_last"},  64'(last),   64'd0);
    check({tag, "_fail"},  64'(fail),   64'd0);
    check({tag, "_served"}, 64'(served), 64'd0);
    check({tag, "_sat_idle"},
          64'({sat_ack, sat_valid, sat_last, sat_fail, sat_served}), 64'd0);
    check({tag, "_sat_data"}, 64'(sat_data), 64'd0);
  endtask

  // Present key at one edge; ack must appear the next cycle, words the one after.
  task automatic load_key(input logic [NB-1:0] k);
    key       = k;
    key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("ack_t1",   64'(ack),   64'd1);
    check("valid_t1", 64'(valid), 64'd0);
    tick();
    check("ack_t2",   64'(ack),   64'd0);
  endtask

  task automatic drain(input logic [NB-1:0] k, input int first, input int stop,
                       input bit bp, input int exp_served);
    for (int w = first; w < stop; w++) begin
      if (bp && (w % 2 == 1)) begin
        word_ready = 1'b0;
        tick();
        check("hold_valid", 64'(valid), 64'd1);
        check("hold_data",  64'(data),  64'(k[w*WW +: WW]));
      end
      check("valid", 64'(valid), 64'd1);
      check("data",  64'(data),  64'(k[w*WW +: WW]));
      check("last",  64'(last),  64'(w == NW - 1));
      word_ready = 1'b1;
      tick();
      word_ready = 1'b0;
    end
    if (stop == NW) begin
      check("done_valid", 64'(valid),      64'd0);
      check("served",     64'(served),     64'(exp_served));
      check("sat_served", 64'(sat_served), 64'((exp_served > 3) ? 3 : exp_served));
    end
  endtask

  initial begin
    logic [NB-1:0] k;
    rst = 1'b1; key_ready = 1'b0; trng_intr = 1'b0; word_ready = 1'b0;
    flush = 1'b0; key = '0;
    tick();
    tick();
    rst = 1'b0;
    check_idle("reset");

    // Nominal key, words 0x0..0xF
    k = make_key(0);
    load_key(k);
    drain(k, 0, NW, 1'b0, 1);

    // Backpressure on every other word
    k = make_key(1);
    load_key(k);
    drain(k, 0, NW, 1'b1, 2);

    // Flush held high from WAIT_KEY (ignored there) into ACK (ack still pulses)
    key = make_key(2); key_ready = 1'b1; flush = 1'b1;
    tick();
    key_ready = 1'b0;
    check("flush_ack_pulse", 64'(ack), 64'd1);
    tick();
    flush = 1'b0;
    check("flush_ack_valid", 64'(valid), 64'd0);
    check("flush_ack_ack",   64'(ack),   64'd0);
    check("flush_ack_srv",   64'(served), 64'd2);

    // Flush mid-SERVE after 5 transfers, ready also high
    k = make_key(3);
    load_key(k);
    drain(k, 0, 5, 1'b0, 0);
    flush = 1'b1; word_ready = 1'b1;
    tick();
    flush = 1'b0; word_ready = 1'b0;
    check("flush_valid", 64'(valid),  64'd0);
    check("flush_data",  64'(data),   64'd0);
    check("flush_srv",   64'(served), 64'd2);
    tick();
    check("flush_wait_ack", 64'(ack), 64'd0);
    k = make_key(4);
    load_key(k);
    drain(k, 0, NW, 1'b0, 3);

    // key_ready while serving is ignored
    k = make_key(5);
    load_key(k);
    key = make_key(9); key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("ign_ack",  64'(ack),  64'd0);
    check("ign_data", 64'(data), 64'(k[WW-1:0]));
    drain(k, 0, NW, 1'b0, 4);

    k = make_key(6);
    load_key(k);
    drain(k, 0, NW, 1'b0, 5);

    // Reset mid-SERVE, then a fresh key
    k = make_key(7);
    load_key(k);
    drain(k, 0, 3, 1'b0, 0);
    rst = 1'b1; word_ready = 1'b1;
    tick();
    rst = 1'b0; word_ready = 1'b0;
    check_idle("rst_mid");
    k = make_key(8);
    load_key(k);
    drain(k, 0, 2, 1'b0, 0);

    // Failure with simultaneous flush and transfer
    trng_intr = 1'b1; flush = 1'b1; word_ready = 1'b1;
    tick();
    trng_intr = 1'b0; flush = 1'b0; word_ready = 1'b0;
    check("fail_flag",  64'(fail),  64'd1);
    check("fail_valid", 64'(valid), 64'd0);
    check("fail_data",  64'(data),  64'd0);
    key = make_key(10); key_ready = 1'b1;
    tick();
    key_ready = 1'b0;
    check("fail_noack", 64'(ack),  64'd0);
    check("fail_stick", 64'(fail), 64'd1);
    tick();
    check("fail_noack2", 64'(ack),   64'd0);
    check("fail_novld",  64'(valid), 64'd0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_idle("fail_rst");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
